// File: rtl/mux_scan_sequencer.sv
// Analog mux scan sequencer: walks the enabled channels, settles the mux, runs the ADC
// and streams results. Define MUX_SCAN_AVG4_EN to average 4 conversions per channel.
module mux_scan_sequencer #(
  parameter int unsigned BASE_ADDR     = 'h10,
  parameter int unsigned SETTLE_CYCLES = 64,
  parameter int unsigned EOC_TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] channel_mask,
  output logic [4:0]  muxaddr_out,
  output logic        convst,
  input  logic        eoc,
  input  logic [15:0] adc_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [15:0] sample_data,
  output logic [3:0]  sample_channel,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    CONVERT,
    WAIT_EOC,
    OUTPUT
  } state_t;

  localparam logic [4:0]  BASE5       = 5'(BASE_ADDR);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  // eoc is accepted up to EOC_TIMEOUT-1 cycles after convst; WAIT_EOC starts one cycle after it
  localparam logic [15:0] TO_LAST     = 16'(EOC_TIMEOUT - 2);

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [3:0]  last_ch;
  logic [3:0]  nxt_ch;
  logic [3:0]  cand;
  logic        nxt_found;
  logic        timeout_hit;

`ifdef MUX_SCAN_AVG4_EN
  logic [1:0]  round;
  logic [17:0] acc;
  logic [17:0] avg_sum;

  assign avg_sum = acc + {2'b00, adc_data};
`endif

  // Search starts just after the last channel; offset 16 wraps back onto it for single-bit masks
  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = last_ch;
    cand      = '0;
    for (int unsigned i = 1; i <= 16; i++) begin
      cand = last_ch + 4'(i);
      if (!nxt_found && channel_mask[cand]) begin
        nxt_found = 1'b1;
        nxt_ch    = cand;
      end
    end
  end

  assign timeout_hit = (state == WAIT_EOC) && !eoc && (cnt == TO_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (enable && (channel_mask != '0)) state_nxt = SELECT;
      SELECT:   state_nxt = nxt_found ? SETTLE : IDLE;
      SETTLE:   if (cnt == SETTLE_LAST) state_nxt = CONVERT;
      CONVERT:  state_nxt = WAIT_EOC;
      WAIT_EOC: begin
        if (eoc) begin
`ifdef MUX_SCAN_AVG4_EN
          state_nxt = (round == 2'd3) ? OUTPUT : CONVERT;
`else
          state_nxt = OUTPUT;
`endif
        end else if (timeout_hit) begin
          state_nxt = enable ? SELECT : IDLE;
        end
      end
      OUTPUT:   if (sample_ready) state_nxt = enable ? SELECT : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign convst       = (state == CONVERT);
  assign busy         = (state != IDLE);
  assign sample_valid = (state == OUTPUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      last_ch        <= '1;
      muxaddr_out    <= BASE5;
      sample_data    <= '0;
      sample_channel <= '0;
      timeout_err    <= 1'b0;
`ifdef MUX_SCAN_AVG4_EN
      round          <= '0;
      acc            <= '0;
`endif
    end else begin
      state <= state_nxt;

      if (state != state_nxt) begin
        cnt <= '0;
      end else if ((state == SETTLE) || (state == WAIT_EOC)) begin
        cnt <= cnt + 16'd1;
      end

      if ((state == SELECT) && nxt_found) begin
        last_ch     <= nxt_ch;
        muxaddr_out <= BASE5 + {1'b0, nxt_ch};
      end

      if (timeout_hit) timeout_err <= 1'b1;

`ifdef MUX_SCAN_AVG4_EN
      if (state == SETTLE) begin
        acc   <= '0;
        round <= '0;
      end
      if ((state == WAIT_EOC) && eoc) begin
        if (round == 2'd3) begin
          sample_data    <= avg_sum[17:2];
          sample_channel <= last_ch;
        end else begin
          acc   <= avg_sum;
          round <= round + 2'd1;
        end
      end
`else
      if ((state == WAIT_EOC) && eoc) begin
        sample_data    <= adc_data;
        sample_channel <= last_ch;
      end
`endif
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer (short settle/timeout overrides for run time).
module tb_mux_scan_sequencer;

  localparam int S  = 8;
  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] channel_mask = '0;
  logic [4:0]  muxaddr_out;
  logic        convst;
  logic        eoc = 1'b0;
  logic [15:0] adc_data = '0;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic [15:0] sample_data;
  logic [3:0]  sample_channel;
  logic        busy;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  mux_scan_sequencer #(
    .BASE_ADDR('h10),
    .SETTLE_CYCLES(S),
    .EOC_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .channel_mask(channel_mask),
    .muxaddr_out(muxaddr_out),
    .convst(convst),
    .eoc(eoc),
    .adc_data(adc_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_data(sample_data),
    .sample_channel(sample_channel),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic wait_convst(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (convst) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // eoc lands k cycles after the convst cycle; returns at the first OUTPUT-cycle negedge
  task automatic pulse_eoc(input int k, input logic [15:0] d);
    repeat (k) @(negedge clk);
    eoc = 1'b1;
    adc_data = d;
    @(negedge clk);
    eoc = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (muxaddr_out !== 5'h10 || convst !== 1'b0 || sample_valid !== 1'b0 || busy !== 1'b0 ||
        timeout_err !== 1'b0 || sample_data !== 16'h0 || sample_channel !== 4'h0) begin
      errors++;
      $display("FAIL reset_values: got mux=%h convst=%b valid=%b busy=%b terr=%b data=%h ch=%h expected mux=10 rest 0",
               muxaddr_out, convst, sample_valid, busy, timeout_err, sample_data, sample_channel);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [15:0] dat [3];
    logic [3:0]  chn [3];
    bit ok;
    dat[0] = 16'h1234; dat[1] = 16'hABCD; dat[2] = 16'h0F0F;
    chn[0] = 4'd0;     chn[1] = 4'd2;     chn[2] = 4'd0;
    channel_mask = 16'h0005;
    sample_ready = 1'b1;
    enable = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_convst(ok);
      checks++;
      if (!ok || muxaddr_out !== (5'h10 + {1'b0, chn[n]})) begin
        errors++;
        $display("FAIL basic_addr%0d: got convst_seen=%b mux=%h expected 1 %h", n, ok, muxaddr_out,
                 5'h10 + {1'b0, chn[n]});
      end
      pulse_eoc(3, dat[n]);
      checks++;
      if (sample_valid !== 1'b1 || sample_data !== dat[n] || sample_channel !== chn[n]) begin
        errors++;
        $display("FAIL basic_sample%0d: got valid=%b data=%h ch=%0d expected 1 %h %0d", n,
                 sample_valid, sample_data, sample_channel, dat[n], chn[n]);
      end
      if (n == 2) enable = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: got busy=%b valid=%b expected 0 0", busy, sample_valid);
    end
  endtask

  task automatic test_wrap;
    logic [4:0] adr [2];
    logic [3:0] chn [2];
    logic [4:0] prev;
    int chg, gap;
    bit found;
    adr[0] = 5'h1F; adr[1] = 5'h10;
    chn[0] = 4'd15; chn[1] = 4'd0;
    channel_mask = 16'h8001;
    enable = 1'b1;
    for (int n = 0; n < 2; n++) begin
      prev = muxaddr_out;
      chg = -1000;
      gap = 0;
      found = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (muxaddr_out !== prev) begin
          chg = i;
          prev = muxaddr_out;
        end
        if (convst) begin
          found = 1'b1;
          gap = i - chg;
          break;
        end
      end
      checks++;
      if (!found || muxaddr_out !== adr[n] || gap !== S) begin
        errors++;
        $display("FAIL wrap_settle%0d: got found=%b mux=%h gap=%0d expected 1 %h %0d", n, found,
                 muxaddr_out, gap, adr[n], S);
      end
      pulse_eoc(2, 16'h7000 + 16'(n));
      checks++;
      if (sample_valid !== 1'b1 || sample_channel !== chn[n]) begin
        errors++;
        $display("FAIL wrap_channel%0d: got valid=%b ch=%0d expected 1 %0d", n, sample_valid,
                 sample_channel, chn[n]);
      end
      if (n == 1) enable = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    bit ok, bad;
    channel_mask = 16'h0003;
    enable = 1'b1;
    wait_convst(ok);
    checks++;
    if (!ok || muxaddr_out !== 5'h11) begin
      errors++;
      $display("FAIL timeout_addr: got convst_seen=%b mux=%h expected 1 11", ok, muxaddr_out);
    end
    bad = 1'b0;
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      if (timeout_err !== 1'b0 || sample_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL timeout_early: got early terr/valid=1 expected 0 before %0d cycles", TO);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_set: got terr=%b valid=%b expected 1 0", timeout_err, sample_valid);
    end
    wait_convst(ok);
    checks++;
    if (!ok || muxaddr_out !== 5'h10) begin
      errors++;
      $display("FAIL timeout_next: got convst_seen=%b mux=%h expected 1 10", ok, muxaddr_out);
    end
    pulse_eoc(1, 16'h0BAD);
    checks++;
    if (sample_valid !== 1'b1 || sample_channel !== 4'd0 || sample_data !== 16'h0BAD ||
        timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_resume: got valid=%b ch=%0d data=%h terr=%b expected 1 0 0bad 1",
               sample_valid, sample_channel, sample_data, timeout_err);
    end
    enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bit ok, bad;
    channel_mask = 16'h0004;
    sample_ready = 1'b0;
    enable = 1'b1;
    wait_convst(ok);
    pulse_eoc(2, 16'h5A5A);
    checks++;
    if (!ok || sample_valid !== 1'b1 || sample_data !== 16'h5A5A || sample_channel !== 4'd2) begin
      errors++;
      $display("FAIL bp_first: got seen=%b valid=%b data=%h ch=%0d expected 1 1 5a5a 2", ok,
               sample_valid, sample_data, sample_channel);
    end
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sample_valid !== 1'b1 || sample_data !== 16'h5A5A || sample_channel !== 4'd2 ||
          convst !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bp_hold: got unstable output or convst=1 expected stable 5a5a ch2 no convst");
    end
    sample_ready = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (sample_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got valid=%b busy=%b expected 0 0", sample_valid, busy);
    end
  endtask

  task automatic test_enable_drop;
    bit ok, bad;
    channel_mask = 16'h0004;
    sample_ready = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_busy: got busy=%b expected 1", busy);
    end
    wait_convst(ok);
    pulse_eoc(2, 16'hC0DE);
    checks++;
    if (!ok || sample_valid !== 1'b1 || sample_data !== 16'hC0DE || sample_channel !== 4'd2) begin
      errors++;
      $display("FAIL drop_sample: got seen=%b valid=%b data=%h ch=%0d expected 1 1 c0de 2", ok,
               sample_valid, sample_data, sample_channel);
    end
    @(negedge clk);
    bad = (busy !== 1'b0) || (sample_valid !== 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (convst !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL drop_idle: got activity after drop expected busy=0 convst=0");
    end
  endtask

  task automatic test_reset_midway;
    bit ok, bad;
    channel_mask = 16'h0001;
    enable = 1'b1;
    wait_convst(ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (!ok || muxaddr_out !== 5'h10 || convst !== 1'b0 || sample_valid !== 1'b0 || busy !== 1'b0 ||
        timeout_err !== 1'b0 || sample_data !== 16'h0 || sample_channel !== 4'h0) begin
      errors++;
      $display("FAIL midrst_values: got seen=%b mux=%h convst=%b valid=%b busy=%b terr=%b data=%h ch=%h expected 1 10 0 0 0 0 0 0",
               ok, muxaddr_out, convst, sample_valid, busy, timeout_err, sample_data, sample_channel);
    end
    enable = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    eoc = 1'b1;
    adc_data = 16'hDEAD;
    @(negedge clk);
    eoc = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sample_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL midrst_eoc: got valid/busy after stray eoc expected 0 0");
    end
    channel_mask = 16'h0003;
    enable = 1'b1;
    wait_convst(ok);
    checks++;
    if (!ok || muxaddr_out !== 5'h10) begin
      errors++;
      $display("FAIL midrst_restart: got seen=%b mux=%h expected 1 10", ok, muxaddr_out);
    end
    enable = 1'b0;
  endtask

`ifdef MUX_SCAN_AVG4_EN
  task automatic test_avg4;
    logic [15:0] dat [4];
    logic [4:0]  prev;
    int chg, last_cv, nconv;
    bit ok, bad;
    dat[0] = 16'd100; dat[1] = 16'd101; dat[2] = 16'd102; dat[3] = 16'd104;
    channel_mask = 16'h0002;
    sample_ready = 1'b1;
    enable = 1'b1;
    prev = muxaddr_out;
    chg = -1000;
    last_cv = 0;
    nconv = 0;
    bad = 1'b0;
    for (int r = 0; r < 4; r++) begin
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (muxaddr_out !== prev) begin
          chg = cyc;
          prev = muxaddr_out;
        end
        if (convst) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) bad = 1'b1;
      nconv++;
      if (r == 0 && (cyc - chg) != S) bad = 1'b1;
      if (r != 0 && (cyc - last_cv) != 3) bad = 1'b1;
      last_cv = cyc;
      pulse_eoc(2, dat[r]);
    end
    enable = 1'b0;
    checks++;
    if (bad || nconv != 4) begin
      errors++;
      $display("FAIL avg_rounds: got bad_timing=%b convst=%0d expected 0 4", bad, nconv);
    end
    checks++;
    if (sample_valid !== 1'b1 || sample_data !== 16'd101 || sample_channel !== 4'd1) begin
      errors++;
      $display("FAIL avg_result: got valid=%b data=%0d ch=%0d expected 1 101 1", sample_valid,
               sample_data, sample_channel);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
`ifdef MUX_SCAN_AVG4_EN
    test_avg4;
`else
    test_basic;
    test_wrap;
    test_timeout;
    test_backpressure;
    test_enable_drop;
    test_reset_midway;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
MUX_SCAN_SEQUENCER -- requirements
Module: mux_scan_sequencer

Interface
REQ-001 Parameter BASE_ADDR, default 'h10: mux address of channel 0; channel n drives BASE_ADDR+n.
REQ-002 Parameter SETTLE_CYCLES, default 64: clk cycles the address is held before a conversion starts, range 1..1023.
REQ-003 Parameter EOC_TIMEOUT, default 1024: clk cycles allowed from convst to eoc, range 2..65535.
REQ-004 One clock; reset is asynchronous and active-high. Ports: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-005 enable  in  1  level; scanning is permitted while high.
REQ-006 channel_mask  in  16  bit n=1 includes channel n; sampled at each channel selection.
REQ-007 muxaddr_out  out  5  external mux address, 5-bit wrap-around of BASE_ADDR+channel.
REQ-008 convst  out  1  one-cycle conversion-start pulse.
REQ-009 eoc  in  1  one-cycle end-of-conversion pulse; adc_data is valid in the same cycle.
REQ-010 adc_data  in  16  conversion result.
REQ-011 sample_valid, sample_ready, sample_data[15:0], sample_channel[3:0]: valid/ready result stream, out/in/out/out.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 timeout_err  out  1  sticky, set on an eoc timeout.

Function
REQ-014 FSM states: IDLE, SELECT, SETTLE, CONVERT, WAIT_EOC, OUTPUT.
REQ-015 IDLE to SELECT when enable=1 and channel_mask!=0; otherwise stay in IDLE.
REQ-016 SELECT picks the next set mask bit strictly after the last channel, searching upward and wrapping 15 to 0; after reset the search starts from channel 0 inclusive; muxaddr_out updates in this cycle; the state then moves to SETTLE.
REQ-017 SETTLE counts SETTLE_CYCLES cycles, then moves to CONVERT; eoc in SETTLE is ignored.
REQ-018 CONVERT asserts convst for exactly one cycle, then moves to WAIT_EOC.
REQ-019 WAIT_EOC captures adc_data on eoc and moves to OUTPUT; eoc in the same cycle as convst is ignored.
REQ-020 If EOC_TIMEOUT cycles pass without eoc: set timeout_err, discard the channel, go to SELECT (or to IDLE if enable=0).
REQ-021 OUTPUT holds sample_valid=1 with stable sample_data/sample_channel until sample_ready=1; the transfer cycle is valid&ready; the next state is SELECT if enable=1, else IDLE.
REQ-022 Deasserting enable mid-channel completes that channel, including its OUTPUT handshake, before IDLE; no partial result is emitted.
REQ-023 A mask bit cleared after the channel is selected does not abort that channel.
REQ-024 A single-bit mask rescans the same channel repeatedly.
REQ-025 muxaddr_out holds its value in IDLE; it never changes during SETTLE, CONVERT or WAIT_EOC.
REQ-026 timeout_err clears only on rst.
REQ-027 Latency from SELECT to sample_valid is 1+SETTLE_CYCLES+1+(convst-to-eoc cycles)+1 clk cycles.

Reset
REQ-028 On rst: state IDLE; muxaddr_out=BASE_ADDR[4:0]; convst=0; sample_valid=0; sample_data=0; sample_channel=0; busy=0; timeout_err=0; all counters 0; last-channel pointer set so the next search starts at channel 0.
REQ-029 rst asserted mid-operation aborts immediately; an in-flight sample is lost and eoc after reset is ignored while in IDLE.

Configuration
REQ-030 Macro MUX_SCAN_AVG4_EN: when defined, each channel performs 4 consecutive CONVERT/WAIT_EOC rounds after a single SETTLE, accumulates them into an 18-bit sum, and outputs sum>>2 (truncated).
REQ-031 With MUX_SCAN_AVG4_EN, a timeout on any round discards the whole channel.
REQ-032 Without MUX_SCAN_AVG4_EN, there is one conversion per channel and sample_data equals adc_data.

Verification
REQ-033 Mask 'h0005, enable=1, eoc 3 cycles after convst, ready=1 -> muxaddr_out 'h10,'h12,'h10..., sample_channel 0,2,0, sample_data equals the injected adc_data.
REQ-034 Mask 'h8001 -> channel order 15 then 0 (wrap), muxaddr_out 'h1F then 'h10; no convst within SETTLE_CYCLES of any address change.
REQ-035 eoc withheld -> timeout_err=1 exactly EOC_TIMEOUT cycles after convst, no sample_valid for that channel, scan continues to the next channel.
REQ-036 sample_ready held 0 for 50 cycles -> sample_valid/data/channel stable, no new convst; single transfer when ready rises.
REQ-037 enable dropped during SETTLE -> that channel's sample is still delivered, then busy=0 and state IDLE; rst during WAIT_EOC -> all REQ-028 values next cycle, no sample_valid.
REQ-038 With MUX_SCAN_AVG4_EN, adc_data 100,101,102,104 -> sample_data=101, 4 convst pulses, 1 settle period.
